mxint_accumulator: RTL

MXINT_ACCUMULATOR -- requirements
Module: mxint_accumulator

---
 rtl/mxint_pkg.sv | 20 ++
 rtl/mxint_align_shift.sv | 17 +
 rtl/mxint_accumulator.sv | 93 +++++++++
 3 files changed

// File: rtl/mxint_pkg.sv
// Shared helpers for the MXINT datapath blocks: derived widths and a small max helper.
package mxint_pkg;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Growth of log2(depth) bits plus one bit of headroom for alignment sums.
    function automatic int acc_man_width(input int man_w, input int depth);
        return man_w + $clog2(depth) + 1;
    endfunction

    // Beat counter needs at least one bit even when depth is 1.
    function automatic int cnt_width(input int depth);
        return max3($clog2(depth), 1, 0);
    endfunction

endpackage

// File: rtl/mxint_align_shift.sv
// Arithmetic right shift that saturates to the sign fill once the distance
// reaches the operand width.
module mxint_align_shift #(
    parameter int WIDTH   = 10,
    parameter int SHIFT_W = 4
) (
    input  logic signed [WIDTH-1:0]   data,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [WIDTH-1:0]   result
);

    always_comb begin
        if (32'(shift) >= 32'(WIDTH)) result = {WIDTH{data[WIDTH-1]}};
        else                          result = data >>> shift;
    end

endmodule

// File: rtl/mxint_accumulator.sv
// Accumulates IN_DEPTH MXINT blocks into one wider block, aligning every beat
// to the larger shared exponent seen so far.
module mxint_accumulator
    import mxint_pkg::*;
#(
    parameter  int IN_MAN_WIDTH  = 8,
    parameter  int IN_EXP_WIDTH  = 4,
    parameter  int BLOCK_SIZE    = 4,
    parameter  int IN_DEPTH      = 4,
    localparam int OUT_MAN_WIDTH = acc_man_width(IN_MAN_WIDTH, IN_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [IN_MAN_WIDTH-1:0]  mdata_in [BLOCK_SIZE],
    input  logic        [IN_EXP_WIDTH-1:0]  edata_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic signed [OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE],
    output logic        [IN_EXP_WIDTH-1:0]  edata_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready
);

    localparam int SHIFT_W = IN_EXP_WIDTH;
    localparam int CNT_W   = cnt_width(IN_DEPTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_DEPTH - 1);

    logic signed [OUT_MAN_WIDTH-1:0] acc      [BLOCK_SIZE];
    logic signed [OUT_MAN_WIDTH-1:0] acc_next [BLOCK_SIZE];
    logic [IN_EXP_WIDTH-1:0] acc_exp, exp_next;
    logic [CNT_W-1:0]        cnt;
    logic                    fire, first, last, in_newer;
    logic [SHIFT_W-1:0]      acc_shift, in_shift;

    assign data_in_ready = !data_out_valid || data_out_ready;
    assign fire          = data_in_valid && data_in_ready;
    assign first         = (cnt == '0);
    assign last          = (cnt == LAST);

    // Only the operand with the smaller exponent is shifted; the other path sees distance 0.
    assign in_newer  = edata_in > acc_exp;
    assign acc_shift = in_newer ? SHIFT_W'(edata_in - acc_exp) : '0;
    assign in_shift  = in_newer ? '0 : SHIFT_W'(acc_exp - edata_in);
    assign exp_next  = (first || in_newer) ? edata_in : acc_exp;

    for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
        logic signed [OUT_MAN_WIDTH-1:0] in_ext, acc_al, in_al;

        assign in_ext = {{(OUT_MAN_WIDTH-IN_MAN_WIDTH){mdata_in[i][IN_MAN_WIDTH-1]}}, mdata_in[i]};

        mxint_align_shift #(.WIDTH(OUT_MAN_WIDTH), .SHIFT_W(SHIFT_W)) u_acc_shift (
            .data   (acc[i]),
            .shift  (acc_shift),
            .result (acc_al)
        );

        mxint_align_shift #(.WIDTH(OUT_MAN_WIDTH), .SHIFT_W(SHIFT_W)) u_in_shift (
            .data   (in_ext),
            .shift  (in_shift),
            .result (in_al)
        );

        assign acc_next[i] = first ? in_ext : acc_al + in_al;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            acc_exp        <= '0;
            edata_out      <= '0;
            data_out_valid <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                acc[i]       <= '0;
                mdata_out[i] <= '0;
            end
        end else begin
            if (fire) begin
                cnt     <= last ? '0 : cnt + 1'b1;
                acc_exp <= exp_next;
                for (int i = 0; i < BLOCK_SIZE; i++) acc[i] <= acc_next[i];
            end
            // A completing group reloads the output even while the previous one transfers.
            if (fire && last) begin
                for (int i = 0; i < BLOCK_SIZE; i++) mdata_out[i] <= acc_next[i];
                edata_out      <= exp_next;
                data_out_valid <= 1'b1;
            end else if (data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule
